// File: rtl/execute_cycle_pkg.sv
// Shared encodings and EX/MEM record for the execute stage.
// Holds the ALU op codes, forward-select codes and the operand mux helper.
package execute_cycle_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } exmem_t;

  // Code 11 is unused by the hazard unit and falls back to the register value.
  function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                             input logic [31:0] reg_val,
                                             input logic [31:0] wb_val,
                                             input logic [31:0] mem_val);
    logic [31:0] res;
    case (sel)
      FWD_WB:  res = wb_val;
      FWD_MEM: res = mem_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// 32-bit ALU: add/sub/and/or/signed slt, purely combinational, zero flag.
// No backpressure; unassigned op codes produce 0.
module alu
  import execute_cycle_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'b0, ($signed(A) < $signed(B))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == 32'h0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: forwarding muxes, ALU, branch resolve; EX/MEM registered, 1-cycle latency.
// No backpressure: loads every cycle; FlushM bubbles control and rd, reset clears all.
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_ExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ALUResultM_fwd,
  input  logic [31:0] ResultW,
  input  logic        FlushM,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a;
  logic [31:0] write_data;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;
  exmem_t      exmem_d;
  exmem_t      exmem_q;

  always_comb begin
    src_a      = fwd_select(ForwardAE, RD1_E, ResultW, ALUResultM_fwd);
    write_data = fwd_select(ForwardBE, RD2_E, ResultW, ALUResultM_fwd);
    src_b      = ALUSrcE ? Imm_ExtE : write_data;
  end

  alu u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_ExtE;

  // A flushed slot still carries data; only the fields that cause side effects are killed.
  always_comb begin
    exmem_d.reg_write  = RegWriteE;
    exmem_d.mem_write  = MemWriteE;
    exmem_d.result_src = ResultSrcE;
    exmem_d.rd         = RD_E;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = write_data;
    exmem_d.pc_plus4   = PCPlus4E;
    if (FlushM) begin
      exmem_d.reg_write  = 1'b0;
      exmem_d.mem_write  = 1'b0;
      exmem_d.result_src = 1'b0;
      exmem_d.rd         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign RegWriteM  = exmem_q.reg_write;
  assign MemWriteM  = exmem_q.mem_write;
  assign ResultSrcM = exmem_q.result_src;
  assign RD_M       = exmem_q.rd;
  assign ALUResultM = exmem_q.alu_result;
  assign WriteDataM = exmem_q.write_data;
  assign PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized + directed bench for execute_cycle against an arithmetic reference model.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM_fwd, ResultW;
  logic        FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_ExtE(Imm_ExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM_fwd(ALUResultM_fwd), .ResultW(ResultW), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_operand(input logic [1:0] sel, input logic [31:0] r,
                                            input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return r;
  endfunction

  // Signed less-than from sign bits and magnitude order, not a signed compare.
  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic lt;
    if (a[31] != b[31]) lt = a[31];
    else                lt = (a < b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + (~b) + 32'd1;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return lt ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    logic [31:0] a, wd, b;
    a  = m_operand(ForwardAE, RD1_E, ResultW, ALUResultM_fwd);
    wd = m_operand(ForwardBE, RD2_E, ResultW, ALUResultM_fwd);
    b  = ALUSrcE ? Imm_ExtE : wd;
    return m_alu(ALUControlE, a, b);
  endfunction

  // Expected registered outputs, and what the next edge should capture.
  logic        e_rw, e_mw, e_rs;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_wd, e_pc4;
  logic        n_rw, n_mw, n_rs;
  logic [4:0]  n_rd;
  logic [31:0] n_alu, n_wd, n_pc4;
  bit          cmp_en = 1'b0;

  task automatic step();
    if (reset) begin
      {n_rw, n_mw, n_rs, n_rd} = '0;
      {n_alu, n_wd, n_pc4} = '0;
    end else begin
      n_rw  = FlushM ? 1'b0 : RegWriteE;
      n_mw  = FlushM ? 1'b0 : MemWriteE;
      n_rs  = FlushM ? 1'b0 : ResultSrcE;
      n_rd  = FlushM ? 5'd0 : RD_E;
      n_alu = m_result();
      n_wd  = m_operand(ForwardBE, RD2_E, ResultW, ALUResultM_fwd);
      n_pc4 = PCPlus4E;
    end
    @(posedge clk);
    #1;
    e_rw = n_rw; e_mw = n_mw; e_rs = n_rs; e_rd = n_rd;
    e_alu = n_alu; e_wd = n_wd; e_pc4 = n_pc4;
    cmp_en = 1'b1;
  endtask

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("PCSrcE",     {31'b0, PCSrcE}, {31'b0, BranchE & (m_result() == 32'd0)});
      check("PCTargetE",  PCTargetE, PCE + Imm_ExtE);
      check("RegWriteM",  {31'b0, RegWriteM},  {31'b0, e_rw});
      check("MemWriteM",  {31'b0, MemWriteM},  {31'b0, e_mw});
      check("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e_rs});
      check("RD_M",       {27'b0, RD_M}, {27'b0, e_rd});
      check("ALUResultM", ALUResultM, e_alu);
      check("WriteDataM", WriteDataM, e_wd);
      check("PCPlus4M",   PCPlus4M, e_pc4);
    end
  end

  task automatic clear_inputs();
    {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE} = '0;
    ALUControlE = 3'd0;
    {RD1_E, RD2_E, Imm_ExtE, PCE, PCPlus4E} = '0;
    RD_E = 5'd0;
    ForwardAE = 2'd0; ForwardBE = 2'd0;
    ALUResultM_fwd = '0; ResultW = '0;
    FlushM = 1'b0;
  endtask

  task automatic randomize_inputs();
    RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
    ResultSrcE = 1'($urandom); BranchE = 1'($urandom);
    ALUControlE = 3'($urandom);
    RD1_E = $urandom; RD2_E = $urandom; Imm_ExtE = $urandom;
    PCE = $urandom; PCPlus4E = $urandom;
    // Occasionally force equal operands so branches resolve taken.
    if ($urandom_range(0, 3) == 0) RD2_E = RD1_E;
    if ($urandom_range(0, 7) == 0) RD1_E = {1'b1, 31'($urandom)};
    RD_E = 5'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    ALUResultM_fwd = $urandom; ResultW = $urandom;
    FlushM = ($urandom_range(0, 5) == 0);
    reset  = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    PCPlus4E = 32'hDEAD_BEEF;
    RegWriteE = 1'b1;
    step();
    check("reset_RegWriteM", {31'b0, RegWriteM}, 32'd0);
    check("reset_PCPlus4M",  PCPlus4M, 32'd0);
    reset = 1'b0;

    // add 5+7 -> 12
    clear_inputs();
    RD1_E = 32'd5; RD2_E = 32'd7; RegWriteE = 1'b1; RD_E = 5'd3;
    step();
    check("add_ALUResultM", ALUResultM, 32'd12);
    check("add_RegWriteM",  {31'b0, RegWriteM}, 32'd1);
    check("add_RD_M",       {27'b0, RD_M}, 32'd3);

    // beq taken
    clear_inputs();
    RD1_E = 32'd9; RD2_E = 32'd9; ALUControlE = 3'b001; BranchE = 1'b1;
    PCE = 32'h100; Imm_ExtE = 32'h10;
    #1;
    check("beq_PCSrcE",    {31'b0, PCSrcE}, 32'd1);
    check("beq_PCTargetE", PCTargetE, 32'h110);
    step();

    // forwarding: 0x20 - 0x3
    clear_inputs();
    RD1_E = 32'h55; RD2_E = 32'h66;
    ForwardAE = 2'b10; ALUResultM_fwd = 32'h20;
    ForwardBE = 2'b01; ResultW = 32'h3; ALUControlE = 3'b001;
    step();
    check("fwd_ALUResultM", ALUResultM, 32'h1D);
    check("fwd_WriteDataM", WriteDataM, 32'h3);

    // signed slt both ways
    clear_inputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; ALUControlE = 3'b101;
    step();
    check("slt_neg_lt_pos", ALUResultM, 32'd1);
    RD1_E = 32'd1; RD2_E = 32'hFFFF_FFFF;
    step();
    check("slt_pos_lt_neg", ALUResultM, 32'd0);

    // add wrap
    clear_inputs();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1;
    step();
    check("wrap_ALUResultM", ALUResultM, 32'd0);
    check("wrap_RegWriteM",  {31'b0, RegWriteM}, 32'd0);

    // flush bubble keeps data
    clear_inputs();
    RD1_E = 32'd5; RD2_E = 32'd7; RegWriteE = 1'b1; MemWriteE = 1'b1; RD_E = 5'd9;
    PCPlus4E = 32'h44; FlushM = 1'b1;
    step();
    check("flush_MemWriteM",  {31'b0, MemWriteM}, 32'd0);
    check("flush_RegWriteM",  {31'b0, RegWriteM}, 32'd0);
    check("flush_RD_M",       {27'b0, RD_M}, 32'd0);
    check("flush_ALUResultM", ALUResultM, 32'd12);
    check("flush_PCPlus4M",   PCPlus4M, 32'h44);

    // load something, then reset together with flush clears it
    FlushM = 1'b0; ResultSrcE = 1'b1;
    step();
    check("pre_reset_RD_M", {27'b0, RD_M}, 32'd9);
    reset = 1'b1; FlushM = 1'b1;
    step();
    check("rstflush_ALUResultM", ALUResultM, 32'd0);
    check("rstflush_WriteDataM", WriteDataM, 32'd0);
    check("rstflush_PCPlus4M",   PCPlus4M, 32'd0);
    check("rstflush_ResultSrcM", {31'b0, ResultSrcM}, 32'd0);
    reset = 1'b0; FlushM = 1'b0;
    step();
    check("post_reset_capture", ALUResultM, 32'd12);

    // randomized traffic with occasional mid-stream reset and flush
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    reset = 1'b0;
    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
